// File: rtl/scandbl_sequencer.sv
// Scan-doubler sequencer: writes source lines into a two-bank line buffer and
// reads each finished line twice at VGA rate. Define SCANDBL_SEQ_STATS_EN for the lines-per-frame counter.
module scandbl_sequencer #(
  parameter int HSYNC_W = 81,
  parameter int VSYNC_W = 2744
) (
  input  logic        clkvga,
  input  logic        rst_n,
  input  logic        ce_video,
  input  logic        hsync_in_n,
  input  logic        vsync_in_n,
  input  logic        enable,
  output logic [10:0] wr_addr,
  output logic        wr_en,
  output logic [10:0] rd_addr,
  output logic        rd_valid,
  output logic        scan_odd,
  output logic        hsync_vga,
  output logic        vsync_vga,
  output logic [9:0]  line_len,
  output logic        ovf,
  output logic [9:0]  lines_per_frame
);
  localparam int HCW = $clog2(HSYNC_W + 1);
  localparam int VCW = $clog2(VSYNC_W + 1);

  typedef enum logic [1:0] {IDLE, PASS0, PASS1, WAIT} state_t;
  state_t state, state_nx;

  logic           sat, locked, vs_armed;
  logic           hs_act, line_done, vs_fall;
  logic [10:0]    rd_nx;
  logic           odd_nx, pass_start;
  logic [HCW-1:0] hcnt;
  logic [VCW-1:0] vcnt;

  assign hs_act    = ce_video & ~hsync_in_n;
  assign line_done = hs_act & locked & (wr_addr[9:7] != 3'd0);
  assign wr_en     = ce_video & ~sat;
  assign vs_fall   = ce_video & ~vsync_in_n & vs_armed;

  // The first hsync after reset only aligns the write address, so the first
  // line_done always follows a complete measured line.
  always_ff @(posedge clkvga or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      line_len <= '0;
      ovf      <= 1'b0;
      sat      <= 1'b0;
      locked   <= 1'b0;
    end else if (ce_video) begin
      if (line_done) begin
        line_len <= wr_addr[9:0];
        wr_addr  <= {~wr_addr[10], 10'd0};
        sat      <= 1'b0;
      end else if (hs_act && !locked) begin
        wr_addr[9:0] <= '0;
        locked       <= 1'b1;
      end else if (wr_addr[9:0] == 10'h3ff) begin
        sat <= 1'b1;
        ovf <= 1'b1;
      end else begin
        wr_addr[9:0] <= wr_addr[9:0] + 10'd1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    rd_nx      = rd_addr;
    odd_nx     = scan_odd;
    pass_start = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
    end else if (line_done) begin
      state_nx   = PASS0;
      rd_nx      = {wr_addr[10], 10'd0};
      odd_nx     = 1'b0;
      pass_start = 1'b1;
    end else begin
      case (state)
        PASS0:
          if (rd_addr[9:0] == line_len) begin
            state_nx   = PASS1;
            rd_nx[9:0] = '0;
            odd_nx     = 1'b1;
            pass_start = 1'b1;
          end else begin
            rd_nx[9:0] = rd_addr[9:0] + 10'd1;
          end
        PASS1:
          if (rd_addr[9:0] == line_len) state_nx = WAIT;
          else rd_nx[9:0] = rd_addr[9:0] + 10'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clkvga or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_addr   <= 11'h400;
      scan_odd  <= 1'b0;
      rd_valid  <= 1'b0;
      hsync_vga <= 1'b1;
      hcnt      <= '0;
    end else begin
      state    <= state_nx;
      rd_addr  <= rd_nx;
      scan_odd <= odd_nx;
      rd_valid <= (state_nx == PASS0) || (state_nx == PASS1);
      if (!enable) begin
        hsync_vga <= 1'b1;
        hcnt      <= '0;
      end else if (pass_start) begin
        hsync_vga <= 1'b0;
        hcnt      <= HCW'(HSYNC_W - 1);
      end else if (hcnt != '0) begin
        hcnt <= hcnt - HCW'(1);
      end else begin
        hsync_vga <= 1'b1;
      end
    end
  end

  // vs_armed holds the last sampled vsync level; a low sample while armed is
  // a falling edge. vsync_vga low means a pulse is running and edges are ignored.
  always_ff @(posedge clkvga or negedge rst_n) begin
    if (!rst_n) begin
      vs_armed  <= 1'b1;
      vsync_vga <= 1'b1;
      vcnt      <= '0;
    end else begin
      if (ce_video) vs_armed <= vsync_in_n;
      if (!enable) begin
        vsync_vga <= 1'b1;
        vcnt      <= '0;
      end else if (vs_fall && vsync_vga) begin
        vsync_vga <= 1'b0;
        vcnt      <= VCW'(VSYNC_W - 1);
      end else if (vcnt != '0) begin
        vcnt <= vcnt - VCW'(1);
      end else begin
        vsync_vga <= 1'b1;
      end
    end
  end

`ifdef SCANDBL_SEQ_STATS_EN
  logic [9:0] line_cnt;

  always_ff @(posedge clkvga or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt        <= '0;
      lines_per_frame <= '0;
    end else if (vs_fall) begin
      lines_per_frame <= line_cnt;
      line_cnt        <= {9'd0, line_done};
    end else if (line_done) begin
      line_cnt <= line_cnt + 10'd1;
    end
  end
`else
  assign lines_per_frame = '0;
`endif

endmodule

// File: doc/scandbl_sequencer.md
SCANDBL_SEQUENCER -- requirements
Module: scandbl_sequencer

Interface
REQ-001 SHALL have parameter HSYNC_W, default 81: VGA hsync low width in clkvga cycles.
REQ-002 SHALL have parameter VSYNC_W, default 2744: VGA vsync low width in clkvga cycles.
REQ-003 SHALL have port clkvga  in  1: the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port ce_video  in  1: one-cycle source-pixel strobe, at most every 2nd clkvga cycle.
REQ-006 SHALL have port hsync_in_n / vsync_in_n  in  1 each: source syncs, sampled on ce_video cycles only.
REQ-007 SHALL have port enable  in  1: 1 runs the read sequencer; 0 parks it.
REQ-008 SHALL have port wr_addr  out  11 and wr_en  out  1: line-buffer write port; bit 10 selects the bank.
REQ-009 SHALL have port rd_addr  out  11 and rd_valid  out  1: line-buffer read port.
REQ-010 SHALL have port scan_odd  out  1: 0 on first read pass, 1 on the repeat pass (dimming select).
REQ-011 SHALL have port hsync_vga, vsync_vga  out  1 each: active-low VGA syncs.
REQ-012 SHALL have port line_len  out  10: last measured source line length minus one.
REQ-013 SHALL have port ovf  out  1: sticky, set when a source line exceeds 1024 pixels.
REQ-014 SHALL have port lines_per_frame  out  10: source lines in the last frame (see Configuration).

Function
REQ-015 wr_en SHALL equal ce_video combinationally, except while wr_addr[9:0] is saturated (REQ-017).
REQ-016 On ce_video with hsync_in_n=0 and wr_addr[9:7]!=0: line_len<=wr_addr[9:0]; wr_addr<={~wr_addr[10],10'd0}; one-cycle internal line_done. Otherwise on ce_video: wr_addr[9:0] increments.
REQ-017 wr_addr[9:0]=1023 without hsync SHALL hold the address, drop wr_en, and set ovf; the next line_done clears saturation only, not ovf.
REQ-018 Read FSM states: IDLE, PASS0, PASS1, WAIT. Reset and enable=0 SHALL force IDLE.
REQ-019 line_done in any non-IDLE-with-enable=0 state SHALL enter PASS0 next cycle: rd_addr={bank just written, 10'd0}, scan_odd=0. This includes mid-pass (resync).
REQ-020 In PASS0/PASS1, rd_addr[9:0] SHALL increment every clkvga cycle and rd_valid=1.
REQ-021 rd_addr[9:0]=line_len in PASS0 SHALL go to PASS1 with rd_addr[9:0]=0 and scan_odd=1; in PASS1 SHALL go to WAIT.
REQ-022 WAIT and IDLE SHALL hold rd_addr and drive rd_valid=0. line_done while in WAIT SHALL start PASS0.
REQ-023 hsync_vga SHALL be low for exactly HSYNC_W cycles from the first cycle of each PASS0 and PASS1. A pass restart SHALL restart the count.
REQ-024 The vsync_in_n falling edge, sampled on ce_video, SHALL drive vsync_vga low for exactly VSYNC_W cycles. Re-arming SHALL require vsync_in_n seen high. Edges during the count SHALL be ignored.
REQ-025 enable=0 SHALL force hsync_vga=1, vsync_vga=1, rd_valid=0. The write side SHALL keep running.
REQ-026 hsync_vga, vsync_vga, rd_valid, scan_odd SHALL be registered outputs, no combinational input-to-output paths. wr_en (REQ-015) is the only exception.

Reset
REQ-027 rst_n=0 SHALL asynchronously set the following:
- wr_addr=0, rd_addr=11'h400, line_len=0
- ovf=0, scan_odd=0, rd_valid=0
- hsync_vga=1, vsync_vga=1
- lines_per_frame=0, FSM=IDLE, vsync armed
REQ-028 Reset release SHALL take effect on the next clkvga edge. The first line_done SHALL NOT occur before a full measured line.

Configuration
REQ-029 Macro SCANDBL_SEQ_STATS_EN defined: a 10-bit counter SHALL increment on each line_done. On each vsync_in_n falling edge it SHALL be copied to lines_per_frame and cleared.
REQ-030 Macro SCANDBL_SEQ_STATS_EN undefined: lines_per_frame SHALL be constant 0 and the counter SHALL be absent.

Verification
REQ-031 ce_video every 2nd cycle, hsync_in_n low every 448 pixels -> line_len=447; rd_addr covers 0..447 twice per line; scan_odd toggles 0->1.
REQ-032 Same stimulus -> hsync_vga low exactly 81 cycles at each pass start, two pulses per source line; bank bits of wr_addr and rd_addr always differ during a pass.
REQ-033 vsync_in_n low for 4 lines -> vsync_vga low exactly 2744 cycles, single pulse; a second low without an intervening high gives no pulse.
REQ-034 Source line of 1100 pixels -> wr_addr holds 1023, wr_en=0, ovf=1; next normal line passes normally; ovf stays 1 until reset.
REQ-035 enable 1->0 mid-PASS0 -> rd_valid=0 and syncs high next cycle; enable 0->1 -> PASS0 starts at the next line_done only.
REQ-036 rst_n pulsed mid-PASS1 -> all outputs at reset values immediately; with STATS_EN, 312 lines per frame -> lines_per_frame=312.
